// File: rtl/inner_loop_accum_pkg.sv
// Shared sizing and FSM encoding for the inner-loop accumulator.
//   Size    : operand width in bits
//   Size_bi : limb width in bits
//   LPC     : limbs resolved per cycle
//   W       : accumulator width (Size + Size_bi + 2)
//   NL / NG : limb count / group count
//   GW / PW : group width / padded working width (NG*LPC limbs)
package inner_loop_accum_pkg;

  localparam int unsigned Size    = 3072;
  localparam int unsigned Size_bi = 64;
  localparam int unsigned LPC     = 8;
  localparam int unsigned W       = Size + Size_bi + 2;
  localparam int unsigned NL      = (W + Size_bi - 1) / Size_bi;
  localparam int unsigned NG      = (NL + LPC - 1) / LPC;
  localparam int unsigned GW      = LPC * Size_bi;
  localparam int unsigned PW      = NG * GW;
  localparam int unsigned GRP_W   = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/inner_loop_accum_limb_add3.sv
// Combinational three-operand limb adder with a 2-bit carry chain.
//   a, b, c : Size_bi-bit limb operands
//   cin     : incoming carry (0..2)
//   sum     : low Size_bi bits of a+b+c+cin
//   cout    : bits above the limb (never exceeds 2 when cin <= 2)
module limb_add3
  import inner_loop_accum_pkg::*;
(
  input  logic [Size_bi-1:0] a,
  input  logic [Size_bi-1:0] b,
  input  logic [Size_bi-1:0] c,
  input  logic [1:0]         cin,
  output logic [Size_bi-1:0] sum,
  output logic [1:0]         cout
);

  logic [Size_bi+1:0] s;

  always_comb begin
    s    = {2'b00, a} + {2'b00, b} + {2'b00, c} + {{Size_bi{1'b0}}, cin};
    sum  = s[Size_bi-1:0];
    cout = s[Size_bi+1:Size_bi];
  end

endmodule

// File: rtl/inner_loop_accum.sv
// Limb-serial resolver of acc + r0 + r1 into a running accumulator, with an
// optional one-limb right shift for the next Montgomery round.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operation strobe / accept (ready only in IDLE)
//   r0, r1              : redundant partial-product pair (W bits)
//   acc_clr, shift_en   : treat old accumulator as zero / shift result right
//   out_valid           : one-cycle pulse when acc_out is updated
//   acc_out, carry_out  : accumulator and its overflow (0 when shifted)
//   err_drop            : sticky, in_valid seen while busy
module inner_loop_accum
  import inner_loop_accum_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  input  logic         acc_clr,
  input  logic         shift_en,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] acc_out,
  output logic         carry_out,
  output logic         err_drop
);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NG - 1);

  state_t             state;
  logic [PW-1:0]      work;
  logic [PW-1:0]      op0;
  logic [PW-1:0]      op1;
  logic [1:0]         carry;
  logic [GRP_W-1:0]   grp;
  logic               shift_r;

  logic [GW-1:0]      grp_sum;
  logic [LPC:0][1:0]  chain;
  logic [W-1:0]       sum_w;
  logic               ovf;
  logic [W-1:0]       shifted;

  assign chain[0] = carry;

  // The three working registers rotate right by one group per ADD cycle, so
  // the adders always see the low group; after NG rotations the resolved sum
  // sits back in its natural limb positions.
  for (genvar i = 0; i < LPC; i++) begin : g_limb
    limb_add3 u_add (
      .a    (work[i*Size_bi +: Size_bi]),
      .b    (op0[i*Size_bi +: Size_bi]),
      .c    (op1[i*Size_bi +: Size_bi]),
      .cin  (chain[i]),
      .sum  (grp_sum[i*Size_bi +: Size_bi]),
      .cout (chain[i+1])
    );
  end

  // Limbs beyond W carry zero operands, so the top-limb overflow bits and the
  // final limb carry land in work[PW-1:W]; any nonzero bit there is carry_out.
  always_comb begin
    sum_w              = work[W-1:0];
    ovf                = |work[PW-1:W];
    shifted            = {{Size_bi{1'b0}}, sum_w[W-1:Size_bi]};
    shifted[W-Size_bi] = ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      work      <= '0;
      op0       <= '0;
      op1       <= '0;
      carry     <= '0;
      grp       <= '0;
      shift_r   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc_out   <= '0;
      carry_out <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && (state != ST_IDLE)) err_drop <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op0      <= PW'(r0);
            op1      <= PW'(r1);
            work     <= acc_clr ? '0 : PW'(acc_out);
            shift_r  <= shift_en;
            carry    <= '0;
            grp      <= '0;
            in_ready <= 1'b0;
            state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          work  <= {grp_sum, work[PW-1:GW]};
          op0   <= op0 >> GW;
          op1   <= op1 >> GW;
          carry <= chain[LPC];
          grp   <= grp + 1'b1;
          if (grp == LAST_GRP) state <= ST_DONE;
        end
        ST_DONE: begin
          acc_out   <= shift_r ? shifted : sum_w;
          carry_out <= shift_r ? 1'b0 : ovf;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inner_loop_accum.sv
module tb_inner_loop_accum;
  import inner_loop_accum_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] r0;
  logic [W-1:0] r1;
  logic         acc_clr;
  logic         shift_en;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] acc_out;
  logic         carry_out;
  logic         err_drop;

  int checks = 0;
  int errors = 0;

  inner_loop_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .r0        (r0),
    .r1        (r1),
    .acc_clr   (acc_clr),
    .shift_en  (shift_en),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .acc_out   (acc_out),
    .carry_out (carry_out),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  // Drives one accepted operation and waits (bounded) for out_valid.
  // lat = negedges after the accept edge's negedge until out_valid is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic clr, input logic sh, output int lat);
    @(negedge clk);
    r0 = a; r1 = b; acc_clr = clr; shift_en = sh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; r0 = '0; r1 = '0; acc_clr = 1'b0; shift_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL reset_acc got %h", acc_out[127:0]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry_out); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_drop); end
  endtask

  task automatic test_simple();
    logic [W-1:0] e;
    int lat;
    e = '0; e[7:0] = 8'd12;
    @(negedge clk);
    r0 = W'(5); r1 = W'(7); acc_clr = 1'b1; shift_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL simple_busy got %b exp 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL simple_latency got %0d exp 8", lat); end
    checks++; if (acc_out !== e) begin errors++; $display("FAIL simple_acc got %h exp %h", acc_out[127:0], e[127:0]); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL simple_carry got %b exp 0", carry_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simple_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_full_ripple();
    logic [W-1:0] ones;
    int lat;
    ones = '1;
    do_op(ones, '0, 1'b1, 1'b0, lat);
    checks++; if (acc_out !== ones) begin errors++; $display("FAIL ripple_setup got %h_%h exp all ones", acc_out[W-1:W-128], acc_out[127:0]); end
    do_op(W'(1), '0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ripple_latency got %0d exp 8", lat); end
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL ripple_acc got %h_%h exp 0", acc_out[W-1:W-128], acc_out[127:0]); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL ripple_carry got %b exp 1", carry_out); end
  endtask

  task automatic test_max_limb_carry();
    logic [W-1:0] m, e;
    int lat;
    m = '0; m[W-3:0] = '1;
    e = '0; e[W-2:1] = '1;
    do_op(m, m, 1'b1, 1'b0, lat);
    checks++; if (acc_out !== e) begin errors++; $display("FAIL maxlimb_acc got %h_%h exp %h_%h", acc_out[W-1:W-128], acc_out[127:0], e[W-1:W-128], e[127:0]); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL maxlimb_carry got %b exp 0", carry_out); end
    // limb 0 = 3*(2^64-1): carry of 2 into limb 1
    m = '0; m[63:0] = '1;
    do_op(m, '0, 1'b1, 1'b0, lat);
    do_op(m, m, 1'b0, 1'b0, lat);
    e = '0; e[63:0] = 64'hFFFF_FFFF_FFFF_FFFD; e[65:64] = 2'b10;
    checks++; if (acc_out !== e) begin errors++; $display("FAIL carry2_acc got %h exp %h", acc_out[127:0], e[127:0]); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL carry2_carry got %b exp 0", carry_out); end
  endtask

  task automatic test_shift();
    logic [W-1:0] a, b, e;
    int lat;
    a = '0; a[65:64] = 2'b11;
    b = '0; b[64] = 1'b1;
    e = '0; e[2] = 1'b1;
    do_op(a, b, 1'b1, 1'b1, lat);
    checks++; if (acc_out !== e) begin errors++; $display("FAIL shift_acc got %h exp %h", acc_out[127:0], e[127:0]); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL shift_carry got %b exp 0", carry_out); end
    // overflow into the shifted-in position
    a = '1;
    do_op(a, '0, 1'b1, 1'b0, lat);
    do_op(W'(1), '0, 1'b0, 1'b1, lat);
    e = '0; e[W-Size_bi] = 1'b1;
    checks++; if (acc_out !== e) begin errors++; $display("FAIL shiftovf_acc got %h_%h exp %h_%h", acc_out[W-1:W-128], acc_out[127:0], e[W-1:W-128], e[127:0]); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL shiftovf_carry got %b exp 0", carry_out); end
  endtask

  task automatic test_handshake();
    logic [W-1:0] e;
    int lat;
    @(negedge clk);
    r0 = W'(10); r1 = W'(20); acc_clr = 1'b1; shift_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    r0 = W'(999); r1 = W'(1); acc_clr = 1'b1; shift_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", err_drop); end
    lat = 3;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    e = '0; e[7:0] = 8'd30;
    checks++; if (lat !== 8) begin errors++; $display("FAIL drop_latency got %0d exp 8", lat); end
    checks++; if (acc_out !== e) begin errors++; $display("FAIL drop_acc got %h exp %h", acc_out[127:0], e[127:0]); end
    // next op issued in the cycle after out_valid
    do_op(W'(5), '0, 1'b0, 1'b0, lat);
    e = '0; e[7:0] = 8'd35;
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got %0d exp 8", lat); end
    checks++; if (acc_out !== e) begin errors++; $display("FAIL b2b_acc got %h exp %h", acc_out[127:0], e[127:0]); end
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky got %b exp 1", err_drop); end
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    @(negedge clk);
    r0 = W'(100); r1 = W'(1); acc_clr = 1'b0; shift_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (acc_out !== '0) begin errors++; $display("FAIL midrst_acc got %h exp 0", acc_out[127:0]); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", err_drop); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valid got %b exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_full_ripple();
    test_max_limb_carry();
    test_shift();
    test_handshake();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
